bcd_scan_decoder: RTL and testbench

- Parametrised, clocked successor to the single-digit combinational BCD-to-decimal decoder.
- Holds DIGITS BCD digits and time-multiplexes them onto one 10-line one-hot decimal bus, with a one-hot digit enable.
- Loads are double-buffered and commit only at frame boundaries, so the display never tears.
- Flags invalid codes (10-15). Sits between the counter/datapath logic and the display/LED drivers.

---
 rtl/bcd_scan_decoder.sv | 142 ++++++++++++++
 tb/tb_bcd_scan_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_decoder.sv
// rtl/bcd_scan_decoder.sv - double-buffered multi-digit BCD scanner with one-hot decimal and digit-enable outputs
// Optional macro BCD_SCAN_ACTIVE_LOW_OUT_EN: when defined, DEC and DIG_EN are driven active-low.
module bcd_scan_decoder #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] BCD_IN,
    input  logic                ERR_CLR,
    output logic [9:0]          DEC,
    output logic [DIGITS-1:0]   DIG_EN,
    output logic                PENDING,
    output logic                FRAME,
    output logic                ERR
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BCD_SCAN_ACTIVE_LOW_OUT_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_display;
    logic                r_pending;
    logic                r_frame;
    logic                r_err;
    logic [9:0]          r_dec;
    logic [DIGITS-1:0]   r_dig_en;

    logic                w_div_last;
    logic                w_idx_last;
    logic                w_wrap;
    logic                w_commit;
    logic                w_shadow_bad;
    logic [3:0]          w_cur_digit;
    logic [9:0]          w_dec_hi;
    logic [DIGITS-1:0]   w_dig_en_hi;

    assign w_div_last = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));
    assign w_wrap     = w_div_last && w_idx_last;
    assign w_commit   = w_wrap && r_pending;

    // Flag any digit of the shadow outside 0..9 so a commit can raise ERR.
    always_comb begin
        w_shadow_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_shadow[4*i +: 4] > 4'd9) begin
                w_shadow_bad = 1'b1;
            end
        end
    end

    // Pick the displayed digit at the current scan index and decode it one-hot.
    always_comb begin
        w_cur_digit = 4'd0;
        w_dig_en_hi = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_digit    = r_display[4*i +: 4];
                w_dig_en_hi[i] = 1'b1;
            end
        end
        w_dec_hi = 10'd0;
        if (w_cur_digit < 4'd10) begin
            w_dec_hi = 10'd1 << w_cur_digit;
        end
    end

    // Scan timing: div counts each digit's dwell, idx steps through the digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_div_last) begin
            r_div <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Double buffer: LOAD fills the shadow, the display only takes it at a frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_display <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_commit) begin
                r_display <= r_shadow;
            end
            if (LOAD) begin
                r_shadow  <= BCD_IN;
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Frame pulse and sticky error; a new error commit beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            if (w_commit && w_shadow_bad) begin
                r_err <= 1'b1;
            end else if (ERR_CLR) begin
                r_err <= 1'b0;
            end
        end
    end

    // Registered display outputs, optionally inverted for active-low drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec    <= {10{OUT_INV}};
            r_dig_en <= {DIGITS{OUT_INV}};
        end else begin
            r_dec    <= w_dec_hi ^ {10{OUT_INV}};
            r_dig_en <= w_dig_en_hi ^ {DIGITS{OUT_INV}};
        end
    end

    assign DEC     = r_dec;
    assign DIG_EN  = r_dig_en;
    assign PENDING = r_pending;
    assign FRAME   = r_frame;
    assign ERR     = r_err;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// tb/tb_bcd_scan_decoder.sv - directed self-checking bench for bcd_scan_decoder (DIGITS=4, SCAN_DIV=2)
module tb_bcd_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        LOAD;
    logic [15:0] BCD_IN;
    logic        ERR_CLR;
    logic [9:0]  DEC;
    logic [3:0]  DIG_EN;
    logic        PENDING;
    logic        FRAME;
    logic        ERR;

    int n_cmp;
    int n_err;
    int k;

    bcd_scan_decoder #(.DIGITS(4), .SCAN_DIV(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .LOAD    (LOAD),
        .BCD_IN  (BCD_IN),
        .ERR_CLR (ERR_CLR),
        .DEC     (DEC),
        .DIG_EN  (DIG_EN),
        .PENDING (PENDING),
        .FRAME   (FRAME),
        .ERR     (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    // Expects to start right after a wrap edge; checks one full 8-edge frame.
    task automatic check_frame(input logic [9:0] d0, input logic [9:0] d1,
                               input logic [9:0] d2, input logic [9:0] d3);
        logic [9:0] exp_dec [4];
        logic [3:0] exp_en;
        exp_dec[0] = d0;
        exp_dec[1] = d1;
        exp_dec[2] = d2;
        exp_dec[3] = d3;
        for (int j = 0; j < 8; j++) begin
            step();
            exp_en = 4'b0001 << (j / 2);
            expect_eq("dec", {22'd0, DEC}, {22'd0, exp_dec[j / 2]});
            expect_eq("dig_en", {28'd0, DIG_EN}, {28'd0, exp_en});
            expect_eq("frame", {31'd0, FRAME}, (j == 7) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        k       = 0;
        rst_n   = 1'b0;
        LOAD    = 1'b0;
        BCD_IN  = 16'h0000;
        ERR_CLR = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_dec", {22'd0, DEC}, 32'h0);
        expect_eq("rst_dig_en", {28'd0, DIG_EN}, 32'h0);
        expect_eq("rst_pending", {31'd0, PENDING}, 32'h0);
        expect_eq("rst_frame", {31'd0, FRAME}, 32'h0);
        expect_eq("rst_err", {31'd0, ERR}, 32'h0);

        rst_n = 1'b1;
        k = 0;
        check_frame(10'h001, 10'h001, 10'h001, 10'h001);

        // Mid-frame load of 1234, committed at the next wrap.
        LOAD = 1'b1; BCD_IN = 16'h1234;
        step();
        LOAD = 1'b0;
        expect_eq("pend_after_load", {31'd0, PENDING}, 32'h1);
        step_to(15);
        expect_eq("pend_before_wrap", {31'd0, PENDING}, 32'h1);
        step_to(16);
        expect_eq("pend_after_commit", {31'd0, PENDING}, 32'h0);
        check_frame(10'h010, 10'h008, 10'h004, 10'h002);

        // Two loads before a wrap: the last one wins.
        LOAD = 1'b1; BCD_IN = 16'h5678;
        step();
        BCD_IN = 16'h9999;
        step();
        LOAD = 1'b0;
        step_to(32);
        check_frame(10'h200, 10'h200, 10'h200, 10'h200);

        // Invalid digit A in slot 1 sets ERR and blanks DEC for that slot.
        LOAD = 1'b1; BCD_IN = 16'h00A0;
        step();
        LOAD = 1'b0;
        expect_eq("err_before_commit", {31'd0, ERR}, 32'h0);
        step_to(48);
        expect_eq("err_set", {31'd0, ERR}, 32'h1);
        check_frame(10'h001, 10'h000, 10'h001, 10'h001);
        expect_eq("err_sticky", {31'd0, ERR}, 32'h1);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        expect_eq("err_cleared", {31'd0, ERR}, 32'h0);

        // Clear coinciding with a commit of another invalid frame: set wins.
        LOAD = 1'b1; BCD_IN = 16'h00F0;
        step();
        LOAD = 1'b0;
        step_to(63);
        ERR_CLR = 1'b1;
        step_to(64);
        ERR_CLR = 1'b0;
        expect_eq("err_set_wins", {31'd0, ERR}, 32'h1);
        check_frame(10'h001, 10'h000, 10'h001, 10'h001);

        // LOAD exactly on the wrap cycle: old shadow commits, new data stays pending.
        LOAD = 1'b1; BCD_IN = 16'h1111;
        step();
        LOAD = 1'b0;
        step_to(79);
        LOAD = 1'b1; BCD_IN = 16'h2222;
        step_to(80);
        LOAD = 1'b0;
        expect_eq("pend_load_on_wrap", {31'd0, PENDING}, 32'h1);
        check_frame(10'h002, 10'h002, 10'h002, 10'h002);
        expect_eq("pend_second_commit", {31'd0, PENDING}, 32'h0);
        check_frame(10'h004, 10'h004, 10'h004, 10'h004);

        // Asynchronous reset mid-frame with data pending.
        LOAD = 1'b1; BCD_IN = 16'h3333;
        step();
        LOAD = 1'b0;
        step();
        expect_eq("pend_pre_reset", {31'd0, PENDING}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_eq("arst_dec", {22'd0, DEC}, 32'h0);
        expect_eq("arst_dig_en", {28'd0, DIG_EN}, 32'h0);
        expect_eq("arst_pending", {31'd0, PENDING}, 32'h0);
        expect_eq("arst_frame", {31'd0, FRAME}, 32'h0);
        expect_eq("arst_err", {31'd0, ERR}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        check_frame(10'h001, 10'h001, 10'h001, 10'h001);
        expect_eq("post_rst_pending", {31'd0, PENDING}, 32'h0);
        expect_eq("post_rst_err", {31'd0, ERR}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
